// File: rtl/dp_pkg.sv
// Shared sizing and state encoding for the LUT dot-product datapath
// (serial unpacker and downstream MAC stage).
package dp_pkg;

    localparam int unsigned ELEM_W     = 8;
    localparam int unsigned N_ELEM     = 8;
    localparam int unsigned FRAME_BITS = 2 * ELEM_W * N_ELEM;
    localparam int unsigned IDX_W      = $clog2(N_ELEM);
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ISSUE = 2'd2
    } dp_state_e;

    typedef logic [ELEM_W-1:0] elem_t;

endpackage

// File: rtl/dp_serial_unpacker_if.sv
// Element handshake bus between the serial unpacker (master) and the
// LUT multiply-accumulate stage (slave).
interface dp_serial_unpacker_if;
    import dp_pkg::*;

    logic             elem_valid;
    logic             elem_ready;
    elem_t            elem_a;
    elem_t            elem_b;
    logic [IDX_W-1:0] elem_idx;
    logic             elem_last;

    modport master (
        output elem_valid,
        output elem_a,
        output elem_b,
        output elem_idx,
        output elem_last,
        input  elem_ready
    );

    modport slave (
        input  elem_valid,
        input  elem_a,
        input  elem_b,
        input  elem_idx,
        input  elem_last,
        output elem_ready
    );

endinterface

// File: rtl/dp_serial_unpacker_sipo_shreg.sv
// Serial-in/parallel-out shift register: shifts right with din entering
// at the MSB, so the first bit shifted in ends at [0] after WIDTH shifts.
module dp_sipo_shreg #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = {din, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/dp_serial_unpacker.sv
// Captures a 128-bit LSB-first frame (A low, B high) after Start, then
// issues the eight (a_j, b_j) byte pairs over a valid/ready handshake.
module dp_serial_unpacker
    import dp_pkg::*;
(
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic                        SerialData,
    dp_serial_unpacker_if.master        elem,
    output logic                        busy
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_SHIFT = 2'(SHIFT);
    localparam logic [1:0] S_ISSUE = 2'(ISSUE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic                  shift_en_c;
    logic [FRAME_BITS-1:0] frame;

    dp_sipo_shreg #(
        .WIDTH (FRAME_BITS)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (Reset),
        .shift_en (shift_en_c),
        .din      (SerialData),
        .dout     (frame)
    );

    // Next-state: Start only matters in IDLE; busy-time Starts are dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_en_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                shift_en_c = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                end
            end
            S_ISSUE: begin
                if (elem.elem_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Element bus is decoded purely from registered state and the frame register.
    assign elem.elem_valid = (state_q == S_ISSUE);
    assign elem.elem_idx   = idx_q;
    assign elem.elem_last  = (idx_q == IDX_LAST);
    assign elem.elem_a     = frame[ELEM_W * 32'(idx_q) +: ELEM_W];
    assign elem.elem_b     = frame[ELEM_W * N_ELEM + ELEM_W * 32'(idx_q) +: ELEM_W];
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_dp_serial_unpacker.sv
// Directed bench for dp_serial_unpacker: nominal frame, latency, backpressure,
// ignored Starts, mid-frame reset and back-to-back frames.
module tb_dp_serial_unpacker;

    logic clk;
    logic Reset;
    logic Start;
    logic SerialData;
    logic busy;

    dp_serial_unpacker_if u_if ();

    dp_serial_unpacker u_dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .SerialData (SerialData),
        .elem       (u_if.master),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_a [8];
    logic [7:0] got_b [8];

    localparam logic [63:0] A1 = 64'h123456789abcdef0;
    localparam logic [63:0] B1 = 64'hfedcba9876543210;
    localparam logic [63:0] A2 = 64'h0101010101010101;
    localparam logic [63:0] B2 = 64'hffffffffffffffff;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge of the first valid cycle.
    task automatic send_frame(input logic [63:0] a, input logic [63:0] b, input int start_bit);
        logic [127:0] fr;
        fr         = {b, a};
        Start      = 1'b1;
        SerialData = ~fr[0];
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            SerialData = fr[i];
            Start      = (i == start_bit);
            if (i == 127) begin
                check("pre_valid", 64'(u_if.elem_valid), 64'd0);
                check("pre_busy", 64'(busy), 64'd1);
            end
            @(negedge clk);
        end
        Start      = 1'b0;
        SerialData = 1'b0;
    endtask

    // Consumes all eight elements; returns at the negedge after the last transfer.
    task automatic drain(input logic [63:0] a, input logic [63:0] b, input int stall_idx,
                         input int stall_n, input int start_idx, output int cycles);
        cycles = 0;
        for (int j = 0; j < 8; j++) begin
            if (j == stall_idx) begin
                u_if.elem_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("stall_valid", 64'(u_if.elem_valid), 64'd1);
                    check("stall_idx", 64'(u_if.elem_idx), 64'(j));
                    check("stall_a", 64'(u_if.elem_a), 64'(a[8*j +: 8]));
                    check("stall_b", 64'(u_if.elem_b), 64'(b[8*j +: 8]));
                    cycles++;
                    @(negedge clk);
                end
                u_if.elem_ready = 1'b1;
            end
            Start = (j == start_idx);
            check("valid", 64'(u_if.elem_valid), 64'd1);
            check("idx", 64'(u_if.elem_idx), 64'(j));
            check("elem_a", 64'(u_if.elem_a), 64'(a[8*j +: 8]));
            check("elem_b", 64'(u_if.elem_b), 64'(b[8*j +: 8]));
            check("last", 64'(u_if.elem_last), 64'(j == 7));
            got_a[j] = u_if.elem_a;
            got_b[j] = u_if.elem_b;
            cycles++;
            @(negedge clk);
            Start = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(u_if.elem_valid), 64'd0);
        check({tag, "_last"}, 64'(u_if.elem_last), 64'd0);
    endtask

    initial begin
        int cyc;
        Reset           = 1'b0;
        Start           = 1'b0;
        SerialData      = 1'b0;
        u_if.elem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(u_if.elem_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_last", 64'(u_if.elem_last), 64'd0);
        check("rst_idx", 64'(u_if.elem_idx), 64'd0);
        check("rst_a", 64'(u_if.elem_a), 64'd0);
        check("rst_b", 64'(u_if.elem_b), 64'd0);
        Reset = 1'b1;
        @(negedge clk);
        check_idle("idle0");

        // Nominal frame, ready tied high
        send_frame(A1, B1, -1);
        drain(A1, B1, -1, 0, -1, cyc);
        check("nom_cycles", 64'(cyc), 64'd8);
        check("nom_a0", 64'(got_a[0]), 64'hf0);
        check("nom_b0", 64'(got_b[0]), 64'h10);
        check("nom_a1", 64'(got_a[1]), 64'hde);
        check("nom_b1", 64'(got_b[1]), 64'h32);
        check("nom_a7", 64'(got_a[7]), 64'h12);
        check("nom_b7", 64'(got_b[7]), 64'hfe);
        check_idle("nom_end");
        @(negedge clk);

        // Backpressure at idx2 for 3 cycles
        send_frame(A1, B1, -1);
        drain(A1, B1, 2, 3, -1, cyc);
        check("bp_cycles", 64'(cyc), 64'd11);
        check("bp_a2", 64'(got_a[2]), 64'hbc);
        check("bp_b2", 64'(got_b[2]), 64'h54);
        check_idle("bp_end");
        @(negedge clk);

        // Start pulses during SHIFT (bit 40) and ISSUE (idx5) are dropped
        send_frame(A1, B1, 40);
        drain(A1, B1, -1, 0, 5, cyc);
        check("ign_cycles", 64'(cyc), 64'd8);
        check_idle("ign_end");
        @(negedge clk);
        check_idle("ign_stay");

        // Reset asserted at bit 70 aborts the frame immediately
        Start      = 1'b1;
        SerialData = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 70; i++) begin
            SerialData = A1[i];
            @(negedge clk);
        end
        Reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(u_if.elem_valid), 64'd0);
        check("abort_idx", 64'(u_if.elem_idx), 64'd0);
        check("abort_a", 64'(u_if.elem_a), 64'd0);
        check("abort_b", 64'(u_if.elem_b), 64'd0);
        @(negedge clk);
        Reset      = 1'b1;
        SerialData = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("abort_hold");
        send_frame(A2, B2, -1);
        drain(A2, B2, -1, 0, -1, cyc);
        for (int j = 0; j < 8; j++) begin
            check("r2_a", 64'(got_a[j]), 64'h01);
            check("r2_b", 64'(got_b[j]), 64'hff);
        end
        check_idle("r2_end");

        // Back-to-back: Start in the first IDLE cycle after the previous frame
        send_frame(A1, B1, -1);
        drain(A1, B1, -1, 0, -1, cyc);
        check("b2b_a0", 64'(got_a[0]), 64'hf0);
        check("b2b_b7", 64'(got_b[7]), 64'hfe);
        check_idle("b2b_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_serial_unpacker.md
Name: dp_serial_unpacker

Overview:
Receive-side front end of the LUT dot-product unit. After a Start pulse it captures a 128-bit LSB-first serial frame: operand A in bits 0..63, operand B in bits 64..127. It then issues the eight (a_j, b_j) byte pairs one at a time over a valid/ready handshake to the downstream LUT multiply-accumulate stage, which produces the 19-bit result and Done.

Parameters:
ELEM_W, 8, element width in bits
N_ELEM, 8, elements per operand
FRAME_BITS, 2*ELEM_W*N_ELEM (128), serial bits per frame (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset)
Start  input  1  frame-start pulse, sampled on clk
SerialData  input  1  serial frame bit, LSB of A first
elem_valid  output  1  elem_a/elem_b/elem_idx/elem_last are valid
elem_ready  input  1  downstream accepts the current element
elem_a  output  ELEM_W  A[ELEM_W*j +: ELEM_W] for j = elem_idx
elem_b  output  ELEM_W  B[ELEM_W*j +: ELEM_W] for j = elem_idx
elem_idx  output  3  element index j, 0..N_ELEM-1
elem_last  output  1  high when elem_idx == N_ELEM-1
busy  output  1  high in SHIFT or ISSUE

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; bit counter=0; element index=0.
  - elem_valid=0, busy=0, elem_last=0, elem_idx=0.
  - elem_a/elem_b=0; frame register cleared.
  - Reset asserted mid-frame or mid-issue aborts the operation with no partial output. The first frame after release needs a new Start.
- States: IDLE, SHIFT, ISSUE.
- IDLE:
  - Start=1 at edge E0 -> SHIFT, counter=0.
  - SerialData is not captured at E0, because the upstream serializer loads its register on that same edge.
- SHIFT:
  - At each edge E0+1+i (i=0..127) capture SerialData as frame bit i.
  - Capture by shift-right of a FRAME_BITS register with SerialData entering at the MSB; after 128 shifts bit 0 sits at [0].
  - Counter is 7 bits and increments per capture.
  - The edge capturing i=127 (counter==127) moves to ISSUE with index=0.
  - Start is ignored in SHIFT.
- ISSUE:
  - elem_valid=1 from the cycle after edge E0+128. Capture-to-first-valid latency is 0 extra cycles.
  - Transfer occurs on an edge with elem_valid & elem_ready.
  - On a transfer with index<N_ELEM-1: index increments and new element data appears next cycle.
  - On a transfer with index==N_ELEM-1: -> IDLE, elem_valid=0 next cycle.
  - While valid & !ready, all elem_* outputs are held stable.
  - With ready tied high, the 8 elements issue on 8 consecutive cycles.
  - Start is ignored in ISSUE, including on the final-transfer edge. A Start that arrives while busy is dropped, not queued.
- busy=1 exactly in SHIFT and ISSUE.
- elem_* outputs are registered or decoded from registered state only. There is no combinational path from elem_ready to elem_valid.
- Unsigned data. No arithmetic in this block; width growth (16-bit products, 19-bit sum) belongs downstream.
- A SerialData of X/Z during SHIFT propagates as-is; there is no checking.

Decomposition:
- Package dp_pkg:
  - ELEM_W, N_ELEM, FRAME_BITS, IDX_W=$clog2(N_ELEM), CNT_W=$clog2(FRAME_BITS).
  - State enum {IDLE, SHIFT, ISSUE}.
  - Shared with the downstream MAC stage.
- One sub-module, dp_sipo_shreg: a FRAME_BITS serial-in/parallel-out shift register with shift-enable, async active-low clear and parallel output.
- The FSM, counters and element mux stay in dp_serial_unpacker.

Test Plan:
- Nominal frame: A=64'h123456789abcdef0, B=64'hfedcba9876543210, ready tied high -> elements issue on 8 consecutive cycles:
  - idx0: a=8'hf0, b=8'h10
  - idx1: a=8'hde, b=8'h32
  - idx7: a=8'h12, b=8'hfe, elem_last=1
  - busy drops the cycle after the idx7 transfer.
- Latency check, same frame: elem_valid first rises in the cycle after edge E0+128; no capture occurs at E0.
- Backpressure: ready low for 3 cycles at idx2 -> elem_a=8'hbc and elem_b=8'h54 held stable with valid=1; idx advances only on the ready edge; total issue takes 11 cycles.
- Start pulse during SHIFT (at bit 40) and during ISSUE (at idx5) -> ignored; the frame and element sequence are unchanged.
- Reset pulsed low at bit 70, then a new Start with A=64'h0101010101010101, B=64'hffffffffffffffff -> all outputs return to reset values immediately; the second frame yields a=8'h01, b=8'hff for all 8 elements.
- Back-to-back frames: Start one cycle after returning to IDLE -> second frame captured correctly, with no bits from the first frame leaking in.
